// File: rtl/rr_arbiter_4to1_65b.sv
// rr_arbiter_4to1_65b
//
// Four-channel round-robin arbiter feeding a one-entry registered output
// stage. Chooses which of four WIDTH-bit sources goes next, reports its index
// in the same 0..3 encoding as the downstream 4:1 select mux, and holds the
// selected word behind a valid/ready handshake.
//
// Ports:
//   clk        single clock, all state updates on the rising edge
//   rst        synchronous, active-high reset
//   in_valid   bit i = channel i presents a word
//   in_data0-3 channel payloads
//   in_ready   one-hot or zero, bit i = channel i's word is taken this cycle
//   out_valid  out_data/out_src hold a word
//   out_data   registered payload
//   out_src    channel index out_data came from
//   out_ready  downstream accepts out_data this cycle
module rr_arbiter_4to1_65b #(
    parameter int WIDTH = 65
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data0,
    input  logic [WIDTH-1:0] in_data1,
    input  logic [WIDTH-1:0] in_data2,
    input  logic [WIDTH-1:0] in_data3,
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       out_src,
    input  logic             out_ready
);

    // Highest-priority channel for the next grant.
    logic [1:0]       ptr;
    logic             load;
    logic             any;
    logic             take;
    logic [1:0]       gnt;
    logic [WIDTH-1:0] gnt_data;

    assign load = !out_valid || out_ready;
    assign any  = |in_valid;
    // rst gates the handshake so no source sees its word taken during reset.
    assign take = load && any && !rst;

    // Scan ptr, ptr+1, ptr+2, ptr+3; the 2-bit sum wraps mod 4 on its own.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        gnt   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && in_valid[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        gnt_data = in_data0;
        case (gnt)
            2'd0: gnt_data = in_data0;
            2'd1: gnt_data = in_data1;
            2'd2: gnt_data = in_data2;
            2'd3: gnt_data = in_data3;
            default: gnt_data = in_data0;
        endcase
    end

    always_comb begin
        in_ready = '0;
        if (take) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt;
            ptr       <= gnt + 2'd1;
        end else if (out_ready) begin
            // Drain with nothing to refill: word leaves, payload and ptr kept.
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arbiter_4to1_65b.sv
// Testbench for rr_arbiter_4to1_65b: directed vector table, hand-written
// backpressure/reset sequences, then randomized traffic checked against a
// behavioural reference model with a fairness bound.
module tb_rr_arbiter_4to1_65b;

    localparam int W = 65;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   in_valid;
    logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   out_src;
    logic         out_ready;

    int total = 0;
    int bad   = 0;

    rr_arbiter_4to1_65b #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data0  (in_data0),
        .in_data1  (in_data1),
        .in_data2  (in_data2),
        .in_data3  (in_data3),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         r;
        logic [3:0]   iv;
        logic         ordy;
        logic [3:0]   rdy;
        logic         ov;
        logic [1:0]   src;
        logic [W-1:0] data;
    } vec_t;

    function automatic logic [W-1:0] wk(input int k);
        logic [W-1:0] one;
        one = 1;
        return (one << 64) | W'(k);
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] iv, input logic ordy,
                                input logic [3:0] rdy, input logic ov, input logic [1:0] src,
                                input logic [W-1:0] data);
        vec_t v;
        v.r = r; v.iv = iv; v.ordy = ordy; v.rdy = rdy; v.ov = ov; v.src = src; v.data = data;
        return v;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, compare just before the next rising edge.
    task automatic row(input vec_t v);
        rst       = v.r;
        in_valid  = v.iv;
        out_ready = v.ordy;
        @(negedge clk);
        chk("in_ready",  W'(in_ready),  W'(v.rdy));
        chk("out_valid", W'(out_valid), W'(v.ov));
        chk("out_src",   W'(out_src),   W'(v.src));
        chk("out_data",  out_data,      v.data);
        @(posedge clk);
        #1;
    endtask

    // Reference model state.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_ptr;
    logic [W-1:0] pdata [4];
    logic [3:0]   pend;
    int           waits [4];

    // Which channel the spec's rules grant this cycle, or -1 for none.
    function automatic int model_grant();
        if (rst) return -1;
        if (m_valid && !out_ready) return -1;
        for (int k = 0; k < 4; k++) begin
            if (in_valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    vec_t tbl [16];

    initial begin
        in_data0 = wk(0);
        in_data1 = wk(1);
        in_data2 = wk(2);
        in_data3 = wk(3);
        rst = 1'b1; in_valid = 4'hF; out_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset, fairness, skip/wrap, drain-to-empty
        tbl[0]  = mk(1, 4'hF, 1, 4'h0, 0, 0, '0);
        tbl[1]  = mk(0, 4'hF, 1, 4'h1, 0, 0, '0);
        tbl[2]  = mk(0, 4'hF, 1, 4'h2, 1, 0, wk(0));
        tbl[3]  = mk(0, 4'hF, 1, 4'h4, 1, 1, wk(1));
        tbl[4]  = mk(0, 4'hF, 1, 4'h8, 1, 2, wk(2));
        tbl[5]  = mk(0, 4'hF, 1, 4'h1, 1, 3, wk(3));
        tbl[6]  = mk(0, 4'hF, 1, 4'h2, 1, 0, wk(0));
        tbl[7]  = mk(0, 4'hF, 1, 4'h4, 1, 1, wk(1));
        tbl[8]  = mk(0, 4'h5, 1, 4'h1, 1, 2, wk(2));
        tbl[9]  = mk(0, 4'h5, 1, 4'h4, 1, 0, wk(0));
        tbl[10] = mk(0, 4'h0, 1, 4'h0, 1, 2, wk(2));
        tbl[11] = mk(0, 4'h0, 1, 4'h0, 0, 2, wk(2));
        tbl[12] = mk(0, 4'h8, 1, 4'h8, 0, 2, wk(2));
        tbl[13] = mk(0, 4'h0, 1, 4'h0, 1, 3, wk(3));
        tbl[14] = mk(0, 4'h0, 1, 4'h0, 0, 3, wk(3));
        tbl[15] = mk(0, 4'hF, 1, 4'h1, 0, 3, wk(3));
        for (int i = 0; i < 16; i++) row(tbl[i]);

        // Backpressure hold: channel 1 loaded, then 5 stalled cycles.
        in_data1 = '1;
        row(mk(0, 4'hF, 1, 4'h2, 1, 0, wk(0)));
        for (int i = 0; i < 5; i++) row(mk(0, 4'hF, 0, 4'h0, 1, 1, '1));
        row(mk(0, 4'hF, 1, 4'h4, 1, 1, '1));
        // Stalled with channel 2 held (ptr = 3), then reset mid-stall.
        row(mk(0, 4'hF, 0, 4'h0, 1, 2, wk(2)));
        row(mk(1, 4'hF, 0, 4'h0, 1, 2, wk(2)));
        row(mk(0, 4'hF, 1, 4'h1, 0, 0, '0));

        // Randomized traffic against the reference model.
        rst = 1'b1; in_valid = '0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
        pend = '0;
        for (int c = 0; c < 4; c++) waits[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            int g;
            for (int c = 0; c < 4; c++) begin
                if (!pend[c] && $urandom_range(0, 2) == 0) begin
                    pend[c]  = 1'b1;
                    pdata[c] = {$urandom, $urandom, $urandom};
                end
            end
            in_valid  = pend;
            in_data0  = pdata[0];
            in_data1  = pdata[1];
            in_data2  = pdata[2];
            in_data3  = pdata[3];
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            @(negedge clk);
            g = model_grant();
            chk("rnd_in_ready",  W'(in_ready), (g < 0) ? '0 : W'(4'b0001 << g));
            chk("rnd_out_valid", W'(out_valid), W'(m_valid));
            chk("rnd_out_src",   W'(out_src), W'(m_src));
            chk("rnd_out_data",  out_data, m_data);
            @(posedge clk);
            if (rst) begin
                m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0;
                for (int c = 0; c < 4; c++) waits[c] = 0;
            end else if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = pdata[g];
                m_src   = g;
                m_ptr   = (g + 1) % 4;
                chk("rnd_fair_wait", W'(waits[g] <= 3), W'(1));
                waits[g] = 0;
                pend[g]  = 1'b0;
                for (int c = 0; c < 4; c++) if (pend[c]) waits[c]++;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
